matrix_row_scan: RTL and testbench



---
 rtl/led_matrix_pkg.sv | 23 ++
 rtl/matrix_row_scan.sv | 140 ++++++++++++++
 tb/tb_matrix_row_scan.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/led_matrix_pkg.sv
// Shared constants and types for the 8x8 LED matrix row/column scan logic.
package led_matrix_pkg;

  localparam int         ROWS    = 8;
  localparam int         SCAN_W  = 3;
  localparam logic [7:0] ROW_OFF = 8'hFF;

  // Octave switch codes; anything else selects the mid octave.
  localparam logic [1:0] SW_LOW  = 2'b00;
  localparam logic [1:0] SW_HIGH = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    BLANK = 2'd2
  } state_t;

  // Active-low one-cold drive pattern for a given row index.
  function automatic logic [ROWS-1:0] row_drive(input logic [SCAN_W-1:0] idx);
    return ~(ROWS'(1) << idx);
  endfunction

endpackage

// File: rtl/matrix_row_scan.sv
// Row-side driver for the 8x8 LED matrix. Time-multiplexes the rows with a
// fixed dwell and optional blanking gap, publishes the row index on scan for
// the column decoder, and freezes the button/switch inputs once per frame.
//
//   state | meaning
//   IDLE  | scanning disabled, all rows off, scan parked at 0
//   DRIVE | row[scan] driven low for DWELL_CYCLES cycles
//   BLANK | all rows off for BLANK_CYCLES cycles before the next row
module matrix_row_scan
  import led_matrix_pkg::*;
#(
  parameter int DWELL_CYCLES = 6250,
  parameter int BLANK_CYCLES = 250,
  parameter int CNT_W        = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [6:0]        btn_in,
  input  logic [1:0]        sw_in,
  output logic [SCAN_W-1:0] scan,
  output logic [ROWS-1:0]   row,
  output logic              blank,
  output logic              frame_start,
  output logic [6:0]        btn_q,
  output logic [1:0]        sw_q
);

  // With no blanking the BLANK state is never entered, so its terminal count
  // only needs to be a legal value.
  localparam int DWELL_LAST = DWELL_CYCLES - 1;
  localparam int BLANK_LAST = (BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [SCAN_W-1:0] r_scan;
  logic [ROWS-1:0]   r_row;
  logic              r_blank;
  logic              r_frame_start;
  logic [6:0]        r_btn_q;
  logic [1:0]        r_sw_q;

  logic              w_dwell_done;
  logic              w_blank_done;
  logic [SCAN_W-1:0] w_scan_next;
  logic              w_wrap;

  assign w_dwell_done = (r_cnt == CNT_W'(DWELL_LAST));
  assign w_blank_done = (r_cnt == CNT_W'(BLANK_LAST));
  assign w_scan_next  = r_scan + SCAN_W'(1);
  assign w_wrap       = (w_scan_next == '0);

  // Scan FSM with dwell/blank counter; all outputs registered alongside state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_scan        <= '0;
      r_row         <= ROW_OFF;
      r_blank       <= 1'b1;
      r_frame_start <= 1'b0;
      r_btn_q       <= '0;
      r_sw_q        <= '0;
    end else if (!en) begin
      // Disable parks the scanner but keeps the last captured inputs.
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_scan        <= '0;
      r_row         <= ROW_OFF;
      r_blank       <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_state       <= DRIVE;
          r_cnt         <= '0;
          r_scan        <= '0;
          r_row         <= row_drive('0);
          r_blank       <= 1'b0;
          r_frame_start <= 1'b1;
          r_btn_q       <= btn_in;
          r_sw_q        <= sw_in;
        end
        DRIVE: begin
          if (w_dwell_done) begin
            r_cnt <= '0;
            if (BLANK_CYCLES == 0) begin
              // Contiguous rows: step straight to the next row.
              r_scan <= w_scan_next;
              r_row  <= row_drive(w_scan_next);
              if (w_wrap) begin
                r_frame_start <= 1'b1;
                r_btn_q       <= btn_in;
                r_sw_q        <= sw_in;
              end
            end else begin
              r_state <= BLANK;
              r_row   <= ROW_OFF;
              r_blank <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        BLANK: begin
          if (w_blank_done) begin
            r_state <= DRIVE;
            r_cnt   <= '0;
            r_scan  <= w_scan_next;
            r_row   <= row_drive(w_scan_next);
            r_blank <= 1'b0;
            if (w_wrap) begin
              r_frame_start <= 1'b1;
              r_btn_q       <= btn_in;
              r_sw_q        <= sw_in;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_scan  <= '0;
          r_row   <= ROW_OFF;
          r_blank <= 1'b1;
        end
      endcase
    end
  end

  assign scan        = r_scan;
  assign row         = r_row;
  assign blank       = r_blank;
  assign frame_start = r_frame_start;
  assign btn_q       = r_btn_q;
  assign sw_q        = r_sw_q;

endmodule

// File: tb/tb_matrix_row_scan.sv
// Bench for matrix_row_scan: a blanking instance (DWELL=4, BLANK=2) and a
// contiguous instance (DWELL=4, BLANK=0) share all inputs. A timeline model
// predicts every output each cycle; a directed table pins down specific points.
module tb_matrix_row_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [6:0] btn_in = '0;
  logic [1:0] sw_in  = '0;

  logic [2:0] scan_a, scan_b;
  logic [7:0] row_a, row_b;
  logic       blank_a, blank_b, fs_a, fs_b;
  logic [6:0] btnq_a, btnq_b;
  logic [1:0] swq_a, swq_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  matrix_row_scan #(.DWELL_CYCLES(4), .BLANK_CYCLES(2), .CNT_W(3)) dut_a (
    .clk(clk), .rst(rst), .en(en), .btn_in(btn_in), .sw_in(sw_in),
    .scan(scan_a), .row(row_a), .blank(blank_a), .frame_start(fs_a),
    .btn_q(btnq_a), .sw_q(swq_a)
  );

  matrix_row_scan #(.DWELL_CYCLES(4), .BLANK_CYCLES(0), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .en(en), .btn_in(btn_in), .sw_in(sw_in),
    .scan(scan_b), .row(row_b), .blank(blank_b), .frame_start(fs_b),
    .btn_q(btnq_b), .sw_q(swq_b)
  );

  // Reference model: each instance is either parked or at time t within its
  // frame. Outputs are derived from t by dividing into row periods.
  int   m_dwell [2] = '{4, 4};
  int   m_blank [2] = '{2, 0};
  bit   m_active[2];
  int   m_t     [2];
  logic [6:0] m_btn[2];
  logic [1:0] m_sw [2];

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int period = m_dwell[i] + m_blank[i];
      if (rst) begin
        m_active[i] = 1'b0;
        m_btn[i]    = '0;
        m_sw[i]     = '0;
      end else if (!en) begin
        m_active[i] = 1'b0;
      end else if (!m_active[i]) begin
        m_active[i] = 1'b1;
        m_t[i]      = 0;
        m_btn[i]    = btn_in;
        m_sw[i]     = sw_in;
      end else begin
        m_t[i] = (m_t[i] + 1) % (8 * period);
        if (m_t[i] == 0) begin
          m_btn[i] = btn_in;
          m_sw[i]  = sw_in;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    for (int i = 0; i < 2; i++) begin
      int period = m_dwell[i] + m_blank[i];
      int e_scan = 0, e_row = 8'hFF, e_blank = 1, e_fs = 0;
      int a_scan, a_row, a_blank, a_fs, a_btn, a_sw;
      if (m_active[i]) begin
        e_scan = m_t[i] / period;
        e_fs   = (m_t[i] == 0) ? 1 : 0;
        if ((m_t[i] % period) < m_dwell[i]) begin
          e_row   = 8'hFF & ~(1 << e_scan);
          e_blank = 0;
        end
      end
      if (i == 0) begin
        a_scan = scan_a; a_row = row_a; a_blank = blank_a; a_fs = fs_a;
        a_btn = btnq_a; a_sw = swq_a;
      end else begin
        a_scan = scan_b; a_row = row_b; a_blank = blank_b; a_fs = fs_b;
        a_btn = btnq_b; a_sw = swq_b;
      end
      chk($sformatf("model[%0d] scan", i), a_scan, e_scan);
      chk($sformatf("model[%0d] row", i), a_row, e_row);
      chk($sformatf("model[%0d] blank", i), a_blank, e_blank);
      chk($sformatf("model[%0d] frame_start", i), a_fs, e_fs);
      chk($sformatf("model[%0d] btn_q", i), a_btn, int'(m_btn[i]));
      chk($sformatf("model[%0d] sw_q", i), a_sw, int'(m_sw[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    model_check();
  endtask

  typedef struct {
    bit         rst;
    bit         en;
    logic [6:0] btn;
    logic [1:0] sw;
    int         n;
    logic [7:0] e_row;
    logic [2:0] e_scan;
    bit         e_blank;
    bit         e_fs;
    logic [6:0] e_btnq;
    logic [1:0] e_swq;
  } vec_t;

  vec_t vecs[14];

  initial begin
    // Directed points on the blanking instance (row period 6, frame 48).
    vecs[0]  = '{1, 0, 7'h00, 2'b00,  2, 8'hFF, 3'd0, 1, 0, 7'h00, 2'b00};
    vecs[1]  = '{0, 1, 7'h00, 2'b00,  1, 8'hFE, 3'd0, 0, 1, 7'h00, 2'b00};
    vecs[2]  = '{0, 1, 7'h00, 2'b00,  1, 8'hFE, 3'd0, 0, 0, 7'h00, 2'b00};
    vecs[3]  = '{0, 1, 7'h00, 2'b00,  3, 8'hFF, 3'd0, 1, 0, 7'h00, 2'b00};
    vecs[4]  = '{0, 1, 7'h00, 2'b00,  2, 8'hFD, 3'd1, 0, 0, 7'h00, 2'b00};
    vecs[5]  = '{0, 1, 7'h00, 2'b00, 13, 8'hF7, 3'd3, 0, 0, 7'h00, 2'b00};
    vecs[6]  = '{0, 0, 7'h00, 2'b00,  1, 8'hFF, 3'd0, 1, 0, 7'h00, 2'b00};
    vecs[7]  = '{0, 1, 7'h00, 2'b00,  1, 8'hFE, 3'd0, 0, 1, 7'h00, 2'b00};
    vecs[8]  = '{0, 1, 7'h00, 2'b00, 10, 8'hFF, 3'd1, 1, 0, 7'h00, 2'b00};
    vecs[9]  = '{0, 1, 7'h40, 2'b11, 37, 8'hFF, 3'd7, 1, 0, 7'h00, 2'b00};
    vecs[10] = '{0, 1, 7'h40, 2'b11,  1, 8'hFE, 3'd0, 0, 1, 7'h40, 2'b11};
    vecs[11] = '{0, 1, 7'h40, 2'b11, 34, 8'hFF, 3'd5, 1, 0, 7'h40, 2'b11};
    vecs[12] = '{1, 1, 7'h40, 2'b11,  1, 8'hFF, 3'd0, 1, 0, 7'h00, 2'b00};
    vecs[13] = '{0, 1, 7'h40, 2'b11,  1, 8'hFE, 3'd0, 0, 1, 7'h40, 2'b11};

    for (int v = 0; v < 14; v++) begin
      rst    = vecs[v].rst;
      en     = vecs[v].en;
      btn_in = vecs[v].btn;
      sw_in  = vecs[v].sw;
      for (int k = 0; k < vecs[v].n; k++) tick();
      chk($sformatf("vec%0d row", v),   int'(row_a),   int'(vecs[v].e_row));
      chk($sformatf("vec%0d scan", v),  int'(scan_a),  int'(vecs[v].e_scan));
      chk($sformatf("vec%0d blank", v), int'(blank_a), int'(vecs[v].e_blank));
      chk($sformatf("vec%0d fs", v),    int'(fs_a),    int'(vecs[v].e_fs));
      chk($sformatf("vec%0d btn_q", v), int'(btnq_a),  int'(vecs[v].e_btnq));
      chk($sformatf("vec%0d sw_q", v),  int'(swq_a),   int'(vecs[v].e_swq));
    end

    // Contiguous instance: frame_start every 32 cycles, no blanking at all.
    btn_in = '0;
    sw_in  = '0;
    rst = 1'b1; tick();
    rst = 1'b0; en = 1'b1; tick();
    chk("contig first fs", int'(fs_b), 1);
    for (int k = 0; k < 64; k++) begin
      tick();
      chk("contig blank low", int'(blank_b), 0);
      chk("contig row/scan", int'(row_b), int'(8'hFF & ~(8'h01 << scan_b)));
    end
    chk("contig fs after 64", int'(fs_b), 1);
    chk("contig row after wrap", int'(row_b), int'(8'hFE));

    // Randomized run with occasional disables and resets.
    for (int k = 0; k < 3000; k++) begin
      rst    = ($urandom_range(0, 299) == 0);
      en     = ($urandom_range(0, 39) != 0);
      btn_in = 7'($urandom);
      sw_in  = 2'($urandom);
      tick();
      // Structural invariants that must hold every cycle.
      chk("rand blank==rowoff A", int'(blank_a), int'(row_a == 8'hFF));
      if (row_a != 8'hFF)
        chk("rand row/scan A", int'(row_a), int'(8'hFF & ~(8'h01 << scan_a)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
